// File: rtl/decoder_pkg.sv
// Shared definitions for the streaming decoder.
//   - Output-format mode constants.
//   - decode(): code/mode/en -> decoded word at the widest supported size.
//     Callers keep the low OP_WIDTH bits. Every format places bit k at
//     position k, so truncating to a narrower word gives the correct result.
package decoder_pkg;

  localparam logic [1:0] MODE_ONEHOT   = 2'b00;
  localparam logic [1:0] MODE_THERM    = 2'b01;
  localparam logic [1:0] MODE_ONEHOT_N = 2'b10;
  localparam logic [1:0] MODE_RSVD     = 2'b11;

  // Widest code the shared decode function handles.
  localparam int DEC_MAX_IP_WIDTH = 10;
  localparam int DEC_MAX_OP_WIDTH = 1 << DEC_MAX_IP_WIDTH;

  typedef logic [DEC_MAX_IP_WIDTH-1:0] dec_code_t;
  typedef logic [DEC_MAX_OP_WIDTH-1:0] dec_word_t;

  function automatic dec_word_t decode(input dec_code_t code,
                                       input logic [1:0] mode,
                                       input logic       en);
    // One bit wider than the result, so that the thermometer mask
    // (1 << (code+1)) - 1 cannot overflow when code is at its maximum.
    logic [DEC_MAX_OP_WIDTH:0] one_hot_ext;
    logic [DEC_MAX_OP_WIDTH:0] therm_ext;
    dec_word_t                 result;
    one_hot_ext = {{DEC_MAX_OP_WIDTH{1'b0}}, 1'b1} << code;
    therm_ext   = (one_hot_ext << 1) - 1'b1;
    result      = '0;
    if (en) begin
      unique case (mode)
        MODE_ONEHOT:   result = one_hot_ext[DEC_MAX_OP_WIDTH-1:0];
        MODE_THERM:    result = therm_ext[DEC_MAX_OP_WIDTH-1:0];
        MODE_ONEHOT_N: result = ~one_hot_ext[DEC_MAX_OP_WIDTH-1:0];
        default:       result = '0;
      endcase
    end
    return result;
  endfunction

endpackage

// File: rtl/decoder_skid.sv
// Generic 2-entry valid/ready skid register.
//   clk, rst_n          : clock and asynchronous active-low reset
//   in_valid / in_ready : upstream handshake. in_ready is registered and
//                         never depends combinationally on out_ready.
//   in_data  [WIDTH]    : upstream word
//   out_valid/out_ready : downstream handshake
//   out_data [WIDTH]    : main output register. It keeps its last value
//                         after it drains.
module decoder_skid #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] main_data_reg, main_data_next;
  logic [WIDTH-1:0] skid_data_reg, skid_data_next;
  logic             main_valid_reg, main_valid_next;
  logic             skid_valid_reg, skid_valid_next;
  logic             in_ready_reg;
  logic             accept;

  assign accept = in_valid & in_ready_reg;

  always_comb begin
    main_data_next  = main_data_reg;
    skid_data_next  = skid_data_reg;
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    if (skid_valid_reg) begin
      // in_ready is low whenever the skid is occupied, so no accept can
      // collide with this refill of the main register.
      if (out_ready) begin
        main_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_reg || out_ready) begin
        main_data_next  = in_data;
        main_valid_next = 1'b1;
      end else begin
        skid_data_next  = in_data;
        skid_valid_next = 1'b1;
      end
    end else if (out_ready) begin
      main_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_reg  <= '0;
      skid_data_reg  <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b0;
    end else begin
      main_data_reg  <= main_data_next;
      skid_data_reg  <= skid_data_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= ~skid_valid_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;

endmodule

// File: rtl/decoder_stream.sv
// Pipelined N-to-2^N decoder on valid/ready streams.
//   clk, rst_n          : clock and asynchronous active-low reset
//   in_valid / in_ready : input handshake. Transfer happens on in_valid & in_ready.
//   en, i, mode         : decode enable, code and output format. These are
//                         sampled only on an input transfer.
//   out_valid/out_ready : output handshake
//   y [OP_WIDTH]        : registered decoded word
//   err                 : sticky flag, set when a reserved mode is accepted
//                         with en=1. It is cleared only by reset.
// IP_WIDTH must be between 1 and decoder_pkg::DEC_MAX_IP_WIDTH.
module decoder_stream
  import decoder_pkg::*;
#(
  parameter  int IP_WIDTH = 4,
  localparam int OP_WIDTH = 1 << IP_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                en,
  input  logic [IP_WIDTH-1:0] i,
  input  logic [1:0]          mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OP_WIDTH-1:0] y,
  output logic                err
);

  dec_word_t           dec_word;
  logic [OP_WIDTH-1:0] dec_data;
  logic                unused_dec;
  logic                accept;
  logic                err_reg;

  assign dec_word   = decode(dec_code_t'(i), mode, en);
  assign dec_data   = dec_word[OP_WIDTH-1:0];
  // The bits above OP_WIDTH are intentionally discarded.
  assign unused_dec = ^dec_word;

  decoder_skid #(
    .WIDTH(OP_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (y)
  );

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (accept && en && mode == MODE_RSVD) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;

endmodule

// File: tb/tb_decoder_stream.sv
// Directed bench for decoder_stream with IP_WIDTH=4.
// It uses a table of streamed vectors plus hand-written sequences for
// backpressure, the reserved mode and reset during a stall.
module tb_decoder_stream;

  localparam int IPW = 4;
  localparam int OPW = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           en = 1'b0;
  logic [IPW-1:0] i = '0;
  logic [1:0]     mode = 2'b00;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [OPW-1:0] y;
  logic           err;

  int checks = 0;
  int errors = 0;

  decoder_stream #(.IP_WIDTH(IPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .en        (en),
    .i         (i),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           en;
    logic [IPW-1:0] code;
    logic [1:0]     mode;
    logic [OPW-1:0] exp_y;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h at %0t", name, act, $time);
    end
  endtask

  task automatic drive(input logic v, input logic e, input logic [IPW-1:0] c, input logic [1:0] m);
    in_valid = v;
    en       = e;
    i        = c;
    mode     = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Build the vector table.
    for (int k = 0; k < 16; k++) begin
      vec_t v;
      v.en = 1'b1;
      v.code = 4'(k);
      v.mode = 2'b00;
      v.exp_y = 16'h0001 << k;
      vecs.push_back(v);
    end
    vecs.push_back('{1'b1, 4'd5,  2'b01, 16'h003F});
    vecs.push_back('{1'b1, 4'd0,  2'b01, 16'h0001});
    vecs.push_back('{1'b1, 4'd15, 2'b01, 16'hFFFF});
    vecs.push_back('{1'b1, 4'd3,  2'b10, 16'hFFF7});
    vecs.push_back('{1'b1, 4'd0,  2'b10, 16'hFFFE});
    vecs.push_back('{1'b0, 4'd9,  2'b00, 16'h0000});
    vecs.push_back('{1'b0, 4'd2,  2'b10, 16'h0000});

    // Reset and idle.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_y", 32'(y), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Streamed table, one beat per cycle, out_ready held high.
    out_ready = 1'b1;
    drive(1'b1, vecs[0].en, vecs[0].code, vecs[0].mode);
    for (int k = 1; k <= vecs.size(); k++) begin
      @(negedge clk);
      check($sformatf("vec%0d_out_valid", k-1), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_y", k-1), 32'(y), 32'(vecs[k-1].exp_y));
      check($sformatf("vec%0d_in_ready", k-1), 32'(in_ready), 32'd1);
      if (k < vecs.size()) drive(1'b1, vecs[k].en, vecs[k].code, vecs[k].mode);
      else drive(1'b0, 1'b0, '0, 2'b00);
    end
    @(negedge clk);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_y_kept", 32'(y), 32'h0000);
    check("en0_no_err", 32'(err), 32'd0);

    // Backpressure: push 1, 2, 3 with out_ready low.
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 4'd1, 2'b00);
    @(negedge clk);
    check("bp_main_valid", 32'(out_valid), 32'd1);
    check("bp_main_y", 32'(y), 32'h0002);
    check("bp_ready_1", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b1, 4'd2, 2'b00);
    @(negedge clk);
    check("bp_skid_ready_low", 32'(in_ready), 32'd0);
    check("bp_stall_y", 32'(y), 32'h0002);
    drive(1'b1, 1'b1, 4'd3, 2'b00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_hold_y", 32'(y), 32'h0002);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_seq_y2", 32'(y), 32'h0004);
    check("bp_seq_valid2", 32'(out_valid), 32'd1);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("bp_seq_y3", 32'(y), 32'h0008);
    check("bp_seq_valid3", 32'(out_valid), 32'd1);
    drive(1'b0, 1'b0, '0, 2'b00);
    @(negedge clk);
    check("bp_no_dup", 32'(out_valid), 32'd0);

    // Reserved mode sets sticky err.
    drive(1'b1, 1'b1, 4'd7, 2'b11);
    @(negedge clk);
    check("rsvd_valid", 32'(out_valid), 32'd1);
    check("rsvd_y", 32'(y), 32'h0000);
    check("rsvd_err", 32'(err), 32'd1);
    drive(1'b1, 1'b1, 4'd4, 2'b00);
    @(negedge clk);
    check("post_rsvd_y", 32'(y), 32'h0010);
    check("err_sticky", 32'(err), 32'd1);
    drive(1'b0, 1'b0, '0, 2'b00);
    @(negedge clk);
    check("err_sticky_idle", 32'(err), 32'd1);

    // Reset mid-stall: fill main and skid, then reset asynchronously.
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 4'd6, 2'b00);
    @(negedge clk);
    drive(1'b1, 1'b1, 4'd7, 2'b00);
    @(negedge clk);
    check("fill_ready_low", 32'(in_ready), 32'd0);
    check("fill_y", 32'(y), 32'h0040);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    check("async_rst_y", 32'(y), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 1'b0, '0, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no_stale_beat", 32'(out_valid), 32'd0);
    end
    check("rst_release_ready", 32'(in_ready), 32'd1);
    check("rst_release_err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
